// File: rtl/alu_ctrl_decoder_if.sv
// Handshake bundle between the instruction decoder, the ALU-control block and the ALU datapath.
// The slave modport is the ALU-control block; the master modport is the surrounding pipeline.
interface alu_ctrl_decoder_if #(
  parameter int TAG_W = 5
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       alu_op_i;
  logic [2:0]       funct3_i;
  logic             funct7b5_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [3:0]       alu_sel_o;
  logic             illegal_o;
  logic [TAG_W-1:0] tag_o;
  logic [7:0]       illegal_cnt_o;

  modport slave (
    input  in_valid_i, alu_op_i, funct3_i, funct7b5_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_sel_o, illegal_o, tag_o, illegal_cnt_o
  );

  modport master (
    output in_valid_i, alu_op_i, funct3_i, funct7b5_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_sel_o, illegal_o, tag_o, illegal_cnt_o
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// ALU-control decoder: maps main-control class plus funct3/funct7b5 to an ALU select code,
// behind a one-cycle output register with a single skid entry so in_ready never depends on out_ready.
module alu_ctrl_decoder #(
  parameter int TAG_W = 5
) (
  input logic                 clk_i,
  input logic                 rst_i,
  alu_ctrl_decoder_if.slave   bus
);
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_ILL = 4'b1111;

  logic [3:0]       w_sel;
  logic             w_illegal;
  logic             w_accept;
  logic             w_consume;

  logic             r_out_valid;
  logic [3:0]       r_out_sel;
  logic             r_out_ill;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [3:0]       r_skid_sel;
  logic             r_skid_ill;
  logic [TAG_W-1:0] r_skid_tag;
  logic [7:0]       r_ill_cnt;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel     = SEL_ILL;
    w_illegal = 1'b1;
    unique case (bus.alu_op_i)
      2'b00: begin w_sel = SEL_ADD; w_illegal = 1'b0; end
      2'b01: begin w_sel = SEL_SUB; w_illegal = 1'b0; end
      2'b10, 2'b11: begin
        case (bus.funct3_i)
          3'b000: begin
            // funct7b5 selects SUB only for R-type; for I-type it is part of the immediate.
            w_sel     = (bus.alu_op_i == 2'b10 && bus.funct7b5_i) ? SEL_SUB : SEL_ADD;
            w_illegal = 1'b0;
          end
          3'b111:  begin w_sel = SEL_AND; w_illegal = 1'b0; end
          3'b110:  begin w_sel = SEL_OR;  w_illegal = 1'b0; end
          default: begin w_sel = SEL_ILL; w_illegal = 1'b1; end
        endcase
      end
      default: begin w_sel = SEL_ILL; w_illegal = 1'b1; end
    endcase
  end

  assign w_accept  = bus.in_valid_i && !r_skid_valid;
  assign w_consume = r_out_valid && bus.out_ready_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_sel    <= 4'b0000;
      r_out_ill    <= 1'b0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_sel   <= 4'b0000;
      r_skid_ill   <= 1'b0;
      r_skid_tag   <= '0;
      r_ill_cnt    <= 8'd0;
    end else begin
      if (w_consume) begin
        if (r_skid_valid) begin
          // Skid drains first; no accept can coincide since in_ready is low while skid is full.
          r_out_sel    <= r_skid_sel;
          r_out_ill    <= r_skid_ill;
          r_out_tag    <= r_skid_tag;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_sel <= w_sel;
          r_out_ill <= w_illegal;
          r_out_tag <= bus.tag_i;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_sel   <= w_sel;
          r_out_ill   <= w_illegal;
          r_out_tag   <= bus.tag_i;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_sel   <= w_sel;
          r_skid_ill   <= w_illegal;
          r_skid_tag   <= bus.tag_i;
        end
      end

      if (w_consume && r_out_ill && r_ill_cnt != 8'hFF) begin
        r_ill_cnt <= r_ill_cnt + 8'd1;
      end
    end
  end

  assign bus.in_ready_o    = !r_skid_valid;
  assign bus.out_valid_o   = r_out_valid;
  assign bus.alu_sel_o     = r_out_sel;
  assign bus.illegal_o     = r_out_ill;
  assign bus.tag_o         = r_out_tag;
  assign bus.illegal_cnt_o = r_ill_cnt;
endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: a scoreboard queue is filled on accept edges and
// drained on consume edges; directed sequences cover latency, back-pressure, saturation and reset.
module tb_alu_ctrl_decoder;
  localparam int TAG_W = 5;

  logic clk;
  logic rst;

  alu_ctrl_decoder_if #(.TAG_W(TAG_W)) bus ();

  alu_ctrl_decoder #(.TAG_W(TAG_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard entry: {illegal, sel[3:0], tag}
  logic [TAG_W+4:0] sb[$];
  int               cnt_model = 0;
  bit               chk_ready_hi = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] model(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    logic [4:0] r;
    r = 5'b1_1111;
    case (op)
      2'b00: r = 5'b0_0010;
      2'b01: r = 5'b0_0110;
      2'b10: begin
        if (f3 == 3'b000)      r = f7 ? 5'b0_0110 : 5'b0_0010;
        else if (f3 == 3'b111) r = 5'b0_0000;
        else if (f3 == 3'b110) r = 5'b0_0001;
      end
      default: begin
        if (f3 == 3'b000)      r = 5'b0_0010;
        else if (f3 == 3'b111) r = 5'b0_0000;
        else if (f3 == 3'b110) r = 5'b0_0001;
      end
    endcase
    return r;
  endfunction

  // Monitor samples one time unit before each rising edge, when all inputs and registered outputs are settled.
  always @(negedge clk) begin
    logic [TAG_W+4:0] exp_e;
    #4;
    if (rst) begin
      sb.delete();
      cnt_model = 0;
    end else begin
      if (chk_ready_hi) check("ready_hi", 32'(bus.in_ready_o), 32'd1);
      if (bus.out_valid_o && bus.out_ready_i) begin
        check("ill_cnt", 32'(bus.illegal_cnt_o), 32'(cnt_model));
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(bus.tag_o), 32'hFFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          check("out_sel", 32'(bus.alu_sel_o), 32'(exp_e[TAG_W+3:TAG_W]));
          check("out_ill", 32'(bus.illegal_o), 32'(exp_e[TAG_W+4]));
          check("out_tag", 32'(bus.tag_o), 32'(exp_e[TAG_W-1:0]));
        end
        if (bus.illegal_o && cnt_model < 255) cnt_model++;
      end
      if (bus.in_valid_i && bus.in_ready_o)
        sb.push_back({model(bus.alu_op_i, bus.funct3_i, bus.funct7b5_i), bus.tag_i});
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic [TAG_W-1:0] t);
    bit acc;
    acc = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.alu_op_i   = op;
    bus.funct3_i   = f3;
    bus.funct7b5_i = f7;
    bus.tag_i      = t;
    for (int n = 0; n < 200 && !acc; n++) begin
      #4;
      acc = bus.in_ready_o && !rst;
      @(negedge clk);
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.alu_op_i   = 2'b00;
    bus.funct3_i   = 3'b000;
    bus.funct7b5_i = 1'b0;
    bus.tag_i      = '0;
    bus.out_ready_i = 1'b0;

    #3;
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_sel",       32'(bus.alu_sel_o), 32'd0);
    check("rst_ill",       32'(bus.illegal_o), 32'd0);
    check("rst_tag",       32'(bus.tag_o), 32'd0);
    check("rst_cnt",       32'(bus.illegal_cnt_o), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single R-type SUB: visible right after the accepting edge
    bus.out_ready_i = 1'b1;
    send(2'b10, 3'b000, 1'b1, 5'd7);
    check("lat_valid", 32'(bus.out_valid_o), 32'd1);
    check("lat_sel",   32'(bus.alu_sel_o), 32'h6);
    check("lat_tag",   32'(bus.tag_o), 32'd7);
    check("lat_ill",   32'(bus.illegal_o), 32'd0);
    wait_drain();

    // Back-to-back stream with the consumer always ready
    chk_ready_hi = 1'b1;
    send(2'b10, 3'b000, 1'b0, 5'd1);
    send(2'b10, 3'b111, 1'b0, 5'd2);
    send(2'b10, 3'b110, 1'b0, 5'd3);
    send(2'b11, 3'b000, 1'b1, 5'd4);
    send(2'b00, 3'b101, 1'b1, 5'd5);
    send(2'b01, 3'b010, 1'b0, 5'd6);
    send(2'b11, 3'b111, 1'b1, 5'd8);
    send(2'b11, 3'b110, 1'b0, 5'd9);
    send(2'b10, 3'b111, 1'b1, 5'd10);
    @(negedge clk);
    chk_ready_hi = 1'b0;
    wait_drain();

    // Back-pressure: two entries fill output and skid, the third waits upstream
    bus.out_ready_i = 1'b0;
    send(2'b00, 3'b000, 1'b0, 5'd1);
    send(2'b01, 3'b000, 1'b0, 5'd2);
    check("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
    fork
      send(2'b10, 3'b110, 1'b0, 5'd3);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold_ready", 32'(bus.in_ready_o), 32'd0);
          check("bp_hold_tag",   32'(bus.tag_o), 32'd1);
          check("bp_hold_sel",   32'(bus.alu_sel_o), 32'h2);
        end
        bus.out_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Illegal results: counter steps and then saturates
    send(2'b10, 3'b001, 1'b0, 5'd11);
    check("ill_sel",  32'(bus.alu_sel_o), 32'hF);
    check("ill_flag", 32'(bus.illegal_o), 32'd1);
    @(negedge clk);
    check("ill_cnt_1", 32'(bus.illegal_cnt_o), 32'd1);
    for (int i = 1; i < 300; i++) send(2'b11, 3'(i % 5 + 1), i[0], 5'(i));
    wait_drain();
    @(negedge clk);
    check("ill_cnt_sat", 32'(bus.illegal_cnt_o), 32'd255);

    // Asynchronous reset with both entries full
    bus.out_ready_i = 1'b0;
    send(2'b00, 3'b000, 1'b0, 5'd20);
    send(2'b01, 3'b000, 1'b0, 5'd21);
    check("full_in_ready", 32'(bus.in_ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready_o), 32'd1);
    check("arst_cnt",       32'(bus.illegal_cnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(bus.out_valid_o), 32'd0);
    check("post_rst_sb",   32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
